// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer in front of ALU32FF: registers one op, holds the ALU
// inputs for an op-class dependent latency, then presents the result to write-back.
module alu_exec_stage #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ctrl,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_ctrl,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  localparam logic [31:0] ALU_CTRL_ADD    = 32'd0;
  localparam logic [31:0] ALU_CTRL_SUB    = 32'd1;
  localparam logic [31:0] ALU_CTRL_AND    = 32'd2;
  localparam logic [31:0] ALU_CTRL_OR     = 32'd3;
  localparam logic [31:0] ALU_CTRL_XOR    = 32'd4;
  localparam logic [31:0] ALU_CTRL_SLL    = 32'd5;
  localparam logic [31:0] ALU_CTRL_SRL    = 32'd6;
  localparam logic [31:0] ALU_CTRL_SRA    = 32'd7;
  localparam logic [31:0] ALU_CTRL_SLT    = 32'd8;
  localparam logic [31:0] ALU_CTRL_SLTU   = 32'd9;
  localparam logic [31:0] ALU_CTRL_MUL    = 32'd10;
  localparam logic [31:0] ALU_CTRL_MULH   = 32'd11;
  localparam logic [31:0] ALU_CTRL_MULHU  = 32'd12;
  localparam logic [31:0] ALU_CTRL_MULHSU = 32'd13;
  localparam logic [31:0] ALU_CTRL_DIV    = 32'd14;
  localparam logic [31:0] ALU_CTRL_DIVU   = 32'd15;
  localparam logic [31:0] ALU_CTRL_REM    = 32'd16;
  localparam logic [31:0] ALU_CTRL_REMU   = 32'd17;

  // Counter preload is LAT-1: completion happens on the edge where cnt is already 0.
  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);
  localparam logic [7:0] ALU_CNT = 8'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  rd_q;
  logic        ill_q;
  logic        accept;
  logic        legal;
  logic [7:0]  lat_m1;

  always_comb begin
    legal  = 1'b1;
    lat_m1 = ALU_CNT;
    case (in_ctrl)
      ALU_CTRL_ADD, ALU_CTRL_SUB, ALU_CTRL_AND, ALU_CTRL_OR, ALU_CTRL_XOR,
      ALU_CTRL_SLL, ALU_CTRL_SRL, ALU_CTRL_SRA, ALU_CTRL_SLT, ALU_CTRL_SLTU:
        lat_m1 = ALU_CNT;
      ALU_CTRL_MUL, ALU_CTRL_MULH, ALU_CTRL_MULHU, ALU_CTRL_MULHSU:
        lat_m1 = MUL_CNT;
      ALU_CTRL_DIV, ALU_CTRL_DIVU, ALU_CTRL_REM, ALU_CTRL_REMU:
        lat_m1 = DIV_CNT;
      default: begin
        legal  = 1'b0;
        lat_m1 = '0;
      end
    endcase
  end

  assign in_ready = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_ctrl  <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      rd_q      <= '0;
      ill_q     <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      // Covers both IDLE and the DONE hand-off that retires the old result.
      alu_ctrl  <= in_ctrl;
      alu_op1   <= in_op1;
      alu_op2   <= in_op2;
      rd_q      <= in_rd;
      ill_q     <= !legal;
      cnt       <= lat_m1;
      out_valid <= 1'b0;
      state     <= EXEC;
    end else begin
      case (state)
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            // An illegal code leaves the ALU output undefined; never sample it.
            out_res   <= ill_q ? '0 : alu_res;
            out_err   <= ill_q;
            out_rd    <= rd_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: acts as the ALU, runs directed cases with literal
// expectations, then random traffic against a deadline-based transaction model.
module tb_alu_exec_stage;

  localparam int MUL_L = 3;
  localparam int DIV_L = 8;
  localparam int ALU_L = 1;

  localparam logic [31:0] C_ADD = 32'd0,  C_SUB = 32'd1,  C_AND = 32'd2,  C_OR = 32'd3;
  localparam logic [31:0] C_XOR = 32'd4,  C_SLL = 32'd5,  C_SRL = 32'd6,  C_SRA = 32'd7;
  localparam logic [31:0] C_SLT = 32'd8,  C_SLTU = 32'd9, C_MUL = 32'd10, C_MULH = 32'd11;
  localparam logic [31:0] C_MULHU = 32'd12, C_MULHSU = 32'd13, C_DIV = 32'd14, C_DIVU = 32'd15;
  localparam logic [31:0] C_REM = 32'd16, C_REMU = 32'd17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ctrl, in_op1, in_op2;
  logic [4:0]  in_rd;
  logic [31:0] alu_ctrl, alu_op1, alu_op2, alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_stage #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .ALU_LAT(ALU_L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rd(out_rd), .out_err(out_err)
  );

  function automatic bit is_legal(input logic [31:0] c);
    return c <= 32'd17;
  endfunction

  function automatic int lat_of(input logic [31:0] c);
    if (!is_legal(c)) return 1;
    if (c >= C_MUL && c <= C_MULHSU) return MUL_L;
    if (c >= C_DIV) return DIV_L;
    return ALU_L;
  endfunction

  function automatic logic [31:0] alu_fn(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic        [63:0] pu;
    logic signed [64:0] psu;
    case (c)
      C_ADD:  return a + b;
      C_SUB:  return a - b;
      C_AND:  return a & b;
      C_OR:   return a | b;
      C_XOR:  return a ^ b;
      C_SLL:  return a << b[4:0];
      C_SRL:  return a >> b[4:0];
      C_SRA:  return $signed(a) >>> b[4:0];
      C_SLT:  return {31'b0, $signed(a) < $signed(b)};
      C_SLTU: return {31'b0, a < b};
      C_MUL:  return a * b;
      C_MULH: begin ps = $signed(a) * $signed(b); return ps[63:32]; end
      C_MULHU: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      C_MULHSU: begin psu = $signed({a[31], a}) * $signed({1'b0, b}); return psu[63:32]; end
      C_DIV: begin
        if (b == 32'd0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      C_DIVU: return (b == 32'd0) ? '1 : a / b;
      C_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return $signed(a) % $signed(b);
      end
      C_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  // The ALU itself; an illegal code yields garbage that must never be captured.
  always_comb alu_res = alu_fn(alu_ctrl, alu_op1, alu_op2);

  // Transaction model: at most one op, completing at a fixed edge number.
  bit          m_busy, m_ov, p_err, m_err;
  int          m_deadline;
  logic [31:0] p_res, m_res, m_ctrl, m_op1, m_op2;
  logic [4:0]  p_rd, m_rd;
  logic        m_in_ready, m_acc;

  always_comb m_in_ready = !flush && (!m_busy || (m_ov && out_ready));
  always_comb m_acc      = in_valid && m_in_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_ov <= 0; m_deadline <= 0;
      p_res <= '0; p_rd <= '0; p_err <= 0;
      m_res <= '0; m_rd <= '0; m_err <= 0;
      m_ctrl <= '0; m_op1 <= '0; m_op2 <= '0;
    end else if (flush) begin
      m_busy <= 0;
      m_ov   <= 0;
    end else if (m_acc) begin
      m_busy     <= 1;
      m_ov       <= 0;
      m_deadline <= cyc + 1 + lat_of(in_ctrl);
      p_res      <= is_legal(in_ctrl) ? alu_fn(in_ctrl, in_op1, in_op2) : 32'd0;
      p_rd       <= in_rd;
      p_err      <= !is_legal(in_ctrl);
      m_ctrl <= in_ctrl; m_op1 <= in_op1; m_op2 <= in_op2;
    end else if (m_ov && out_ready) begin
      m_ov   <= 0;
      m_busy <= 0;
    end else if (m_busy && !m_ov && (cyc + 1 == m_deadline)) begin
      m_ov  <= 1;
      m_res <= p_res;
      m_rd  <= p_rd;
      m_err <= p_err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready",  {31'b0, in_ready},  {31'b0, m_in_ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) begin
        check("out_res", out_res, m_res);
        check("out_rd",  {27'b0, out_rd}, {27'b0, m_rd});
        check("out_err", {31'b0, out_err}, {31'b0, m_err});
      end
      check("alu_ctrl", alu_ctrl, m_ctrl);
      check("alu_op1",  alu_op1,  m_op1);
      check("alu_op2",  alu_op2,  m_op2);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] r, output int acc_at);
    bit rdy;
    in_ctrl = c; in_op1 = a; in_op2 = b; in_rd = r; in_valid = 1'b1;
    acc_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); rdy = in_ready;
      tick();
      if (rdy) begin acc_at = cyc; break; end
    end
    in_valid = 1'b0;
    if (acc_at < 0) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(output int v_at);
    v_at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin v_at = cyc; break; end
    end
    if (v_at < 0) check("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input string nm, input logic [31:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input int lat,
                          input logic [31:0] res, input bit err);
    int acc, v;
    send(c, a, b, r, acc);
    wait_out(v);
    check({nm, "_lat"}, 32'(v - acc), 32'(lat));
    check({nm, "_res"}, out_res, res);
    check({nm, "_rd"},  {27'b0, out_rd}, {27'b0, r});
    check({nm, "_err"}, {31'b0, out_err}, {31'b0, err});
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, t0, v;
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_op1 = '0; in_op2 = '0; in_rd = '0;
    #1;
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_ctrl",  alu_ctrl, 32'd0);
    check("rst_out_res",   out_res, 32'd0);
    check("rst_out_err",   {31'b0, out_err}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    directed("add", C_ADD, 32'd5, 32'd7, 5'd3, 1, 32'd12, 1'b0);
    directed("mul", C_MUL, 32'hFFFF_FFFF, 32'd2, 5'd4, 3, 32'hFFFF_FFFE, 1'b0);
    directed("div", C_DIV, 32'd100, 32'd7, 5'd5, 8, 32'd14, 1'b0);
    directed("ill", 32'hDEAD_BEEF, 32'd1, 32'd2, 5'd6, 1, 32'd0, 1'b1);

    // Backpressure, then hand-off on the same edge as the retire.
    out_ready = 1'b0;
    send(C_SUB, 32'd9, 32'd4, 5'd9, acc);
    wait_out(v);
    tick();
    in_ctrl = C_OR; in_op1 = 32'hA; in_op2 = 32'h5; in_rd = 5'd10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_res", out_res, 32'd5);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    t0 = cyc;
    send(C_OR, 32'hA, 32'h5, 5'd10, acc);
    check("b2b_accept_edge", 32'(acc), 32'(t0 + 1));
    wait_out(v);
    check("b2b_lat", 32'(v - acc), 32'd1);
    check("b2b_res", out_res, 32'hF);
    tick();

    // Flush one cycle into a DIV with another op offered.
    send(C_DIV, 32'd100, 32'd7, 5'd1, acc);
    flush = 1'b1;
    in_ctrl = C_ADD; in_op1 = 32'd1; in_op2 = 32'd1; in_rd = 5'd2; in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_valid", {31'b0, seen}, 32'd0);
    directed("xor", C_XOR, 32'hF0, 32'hFF, 5'd7, 1, 32'h0F, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    send(C_MUL, 32'd3, 32'd4, 5'd2, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("arst_alu_op1",   alu_op1, 32'd0);
    check("arst_out_res",   out_res, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_ctrl   = ($urandom_range(0, 9) != 0) ? 32'($urandom_range(0, 17)) : $urandom;
      in_op1    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      in_op2    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      in_rd     = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
